// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and formatted load returns onto the
// single register-file write port. Loads are tracked in issue order through a
// meta FIFO (awaiting response) and a result FIFO (awaiting writeback) so ALU
// writebacks never stall.
// Optional: define WB_SCOREBOARD_EN to add the rd_pending per-register output.
module writeback_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_rd,
  input  logic [31:0]               alu_data,
  input  logic                      ld_issue_valid,
  output logic                      ld_issue_ready,
  input  logic [4:0]                ld_rd,
  input  logic [2:0]                ld_funct3,
  input  logic [1:0]                ld_offset,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic                      write_enable,
  output logic [4:0]                write_address,
  output logic [31:0]               write_data,
  output logic [$clog2(DEPTH):0]    ld_outstanding,
  output logic                      resp_err
`ifdef WB_SCOREBOARD_EN
  ,output logic [31:0]              rd_pending
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } meta_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  meta_t             meta_mem_q [DEPTH];
  meta_t             meta_mem_d [DEPTH];
  logic [PTR_W-1:0]  meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d;
  logic [CNT_W-1:0]  meta_cnt_q, meta_cnt_d;

  res_t              res_mem_q [DEPTH];
  res_t              res_mem_d [DEPTH];
  logic [PTR_W-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;

  logic              we_q, we_d;
  logic [4:0]        wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;

  logic              issue_acc;
  logic              resp_ok;
  logic              res_pop;
  meta_t             meta_head;
  res_t              res_head;

  // Extract and extend the addressed byte/halfword of a returned word
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign ld_outstanding = meta_cnt_q + res_cnt_q;
  assign ld_issue_ready = (ld_outstanding < CNT_W'(DEPTH));
  assign write_enable   = we_q;
  assign write_address  = wa_q;
  assign write_data     = wd_q;
  assign resp_err       = err_q;

  // FIFO bookkeeping, response formatting and write-port arbitration
  always_comb begin
    meta_mem_d = meta_mem_q;
    meta_wr_d  = meta_wr_q;
    meta_rd_d  = meta_rd_q;
    meta_cnt_d = meta_cnt_q;
    res_mem_d  = res_mem_q;
    res_wr_d   = res_wr_q;
    res_rd_d   = res_rd_q;
    res_cnt_d  = res_cnt_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    err_d      = err_q;

    meta_head  = meta_mem_q[meta_rd_q];
    res_head   = res_mem_q[res_rd_q];
    issue_acc  = ld_issue_valid && ld_issue_ready;
    resp_ok    = mem_rvalid && (meta_cnt_q != '0);
    res_pop    = !alu_valid && (res_cnt_q != '0);

    if (mem_rvalid && (meta_cnt_q == '0)) err_d = 1'b1;

    if (issue_acc) begin
      meta_mem_d[meta_wr_q] = '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};
      meta_wr_d = PTR_W'(meta_wr_q + 1'b1);
    end
    if (resp_ok) begin
      meta_rd_d = PTR_W'(meta_rd_q + 1'b1);
      res_mem_d[res_wr_q] = '{rd: meta_head.rd,
                              data: fmt_load(meta_head.funct3, meta_head.offset, mem_rdata)};
      res_wr_d = PTR_W'(res_wr_q + 1'b1);
    end
    if (res_pop) res_rd_d = PTR_W'(res_rd_q + 1'b1);

    case ({issue_acc, resp_ok})
      2'b10:   meta_cnt_d = meta_cnt_q + CNT_W'(1);
      2'b01:   meta_cnt_d = meta_cnt_q - CNT_W'(1);
      default: meta_cnt_d = meta_cnt_q;
    endcase
    case ({resp_ok, res_pop})
      2'b10:   res_cnt_d = res_cnt_q + CNT_W'(1);
      2'b01:   res_cnt_d = res_cnt_q - CNT_W'(1);
      default: res_cnt_d = res_cnt_q;
    endcase

    if (alu_valid) begin
      we_d = (alu_rd != 5'd0);
      wa_d = alu_rd;
      wd_d = alu_data;
    end else if (res_pop) begin
      we_d = (res_head.rd != 5'd0);
      wa_d = res_head.rd;
      wd_d = res_head.data;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        meta_mem_q[i] <= '0;
        res_mem_q[i]  <= '0;
      end
      meta_wr_q  <= '0;
      meta_rd_q  <= '0;
      meta_cnt_q <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      meta_mem_q <= meta_mem_d;
      res_mem_q  <= res_mem_d;
      meta_wr_q  <= meta_wr_d;
      meta_rd_q  <= meta_rd_d;
      meta_cnt_q <= meta_cnt_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_cnt_q  <= res_cnt_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [CNT_W-1:0] sb_cnt_q [1:31];
  logic [CNT_W-1:0] sb_cnt_d [1:31];

  // Per-register count of loads in flight; up on accepted issue, down on writeback pop
  always_comb begin
    rd_pending = '0;
    for (int unsigned n = 1; n < 32; n++) begin
      sb_cnt_d[n] = sb_cnt_q[n];
      if (issue_acc && (ld_rd == 5'(n)))   sb_cnt_d[n] = sb_cnt_d[n] + CNT_W'(1);
      if (res_pop && (res_head.rd == 5'(n))) sb_cnt_d[n] = sb_cnt_d[n] - CNT_W'(1);
      rd_pending[n] = (sb_cnt_q[n] != '0);
    end
  end

  // Scoreboard counter registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned n = 1; n < 32; n++) sb_cnt_q[n] <= '0;
    end else begin
      sb_cnt_q <= sb_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized stimulus for writeback_unit,
// checked against a queue-based reference model of the load pipeline.
module tb_writeback_unit;

  logic        clk_i;
  logic        reset_i;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [2:0]  ld_outstanding;
  logic        resp_err;
`ifdef WB_SCOREBOARD_EN
  logic [31:0] rd_pending;
`endif

  writeback_unit #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_offset      (ld_offset),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .ld_outstanding (ld_outstanding),
    .resp_err       (resp_err)
`ifdef WB_SCOREBOARD_EN
    ,.rd_pending    (rd_pending)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_res_t;

  ld_req_t     mq[$];
  ld_res_t     rq[$];
  logic        exp_we;
  logic        exp_sel;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  logic        exp_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * off[1]));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int          outst;
    logic [31:0] pend;
    outst = mq.size() + rq.size();
    check("write_enable", 32'(write_enable), 32'(exp_we));
    if (exp_sel) begin
      check("write_address", 32'(write_address), 32'(exp_wa));
      check("write_data", write_data, exp_wd);
    end
    check("ld_outstanding", 32'(ld_outstanding), 32'(outst));
    check("ld_issue_ready", 32'(ld_issue_ready), 32'(outst < 4));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    pend = '0;
    foreach (mq[i]) if (mq[i].rd != 0) pend[mq[i].rd] = 1'b1;
    foreach (rq[i]) if (rq[i].rd != 0) pend[rq[i].rd] = 1'b1;
`ifdef WB_SCOREBOARD_EN
    check("rd_pending", rd_pending, pend);
`else
    if (pend == 32'hFFFF_FFFF) $display("[TB] every register pending");
`endif
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge
  task automatic step();
    int      outst;
    ld_res_t r;
    ld_req_t m;
    outst   = mq.size() + rq.size();
    exp_sel = 1'b0;
    exp_we  = 1'b0;
    if (alu_valid) begin
      exp_sel = 1'b1;
      exp_we  = (alu_rd != 0);
      exp_wa  = alu_rd;
      exp_wd  = alu_data;
    end else if (rq.size() > 0) begin
      r       = rq.pop_front();
      exp_sel = 1'b1;
      exp_we  = (r.rd != 0);
      exp_wa  = r.rd;
      exp_wd  = r.data;
    end
    if (mem_rvalid) begin
      if (mq.size() > 0) begin
        m = mq.pop_front();
        rq.push_back('{rd: m.rd, data: ref_fmt(m.f3, m.off, mem_rdata)});
      end else begin
        exp_err = 1'b1;
      end
    end
    if (ld_issue_valid && outst < 4)
      mq.push_back('{rd: ld_rd, f3: ld_funct3, off: ld_offset});
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic idle();
    alu_valid      = 1'b0;
    ld_issue_valid = 1'b0;
    mem_rvalid     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b0;
    #1;
    mq.delete();
    rq.delete();
    exp_we  = 1'b0;
    exp_sel = 1'b1;
    exp_wa  = '0;
    exp_wd  = '0;
    exp_err = 1'b0;
    check_all();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    idle();
    ld_issue_valid = 1'b1;
    ld_rd          = rd;
    ld_funct3      = f3;
    ld_offset      = off;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] word, input logic [31:0] expv);
    issue(rd, f3, off);
    step();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    step();
    idle();
    step();
    check("load_data", write_data, expv);
    check("load_addr", 32'(write_address), 32'(rd));
  endtask

  initial begin
    reset_i = 1'b0;
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; mem_rdata = '0;
    idle();
    #2;
    do_reset();

    // ALU write lands one cycle later
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    check("alu_we", 32'(write_enable), 32'd1);
    check("alu_data", write_data, 32'h1234);
    idle();
    step();

    // Load formatting
    do_load(5'd3, 3'b000, 2'd2, 32'h0080FF00, 32'hFFFFFF80);
    do_load(5'd3, 3'b100, 2'd2, 32'h0080FF00, 32'h00000080);
    do_load(5'd3, 3'b101, 2'd2, 32'h0080FF00, 32'h00000080);
    do_load(5'd3, 3'b001, 2'd0, 32'h0080FF00, 32'hFFFFFF00);
    do_load(5'd6, 3'b010, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load(5'd6, 3'b111, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);

    // Fill to DEPTH, overflow issue ignored, ALU holds the port while responses land
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 3'b010, 2'd0);
      step();
    end
    check("full_ready", 32'(ld_issue_ready), 32'd0);
    issue(5'd9, 3'b010, 2'd0);
    step();
    check("full_outst", 32'(ld_outstanding), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      idle();
      alu_valid  = 1'b1;
      alu_rd     = 5'($urandom_range(1, 31));
      alu_data   = $urandom;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h100 * i;
      step();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      check("drain_we", 32'(write_enable), 32'd1);
      check("drain_addr", 32'(write_address), 32'(i));
    end
    check("drain_outst", 32'(ld_outstanding), 32'd0);

    // Writes to x0 are suppressed but loads still retire
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    check("x0_alu_we", 32'(write_enable), 32'd0);
    do_load(5'd0, 3'b010, 2'd0, 32'h77, 32'h77);
    check("x0_ld_we", 32'(write_enable), 32'd0);
    check("x0_outst", 32'(ld_outstanding), 32'd0);

    // Spurious response sets the sticky error
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h1;
    step();
    check("resp_err_set", 32'(resp_err), 32'd1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      alu_valid      = ($urandom_range(0, 3) == 0);
      alu_rd         = 5'($urandom);
      alu_data       = $urandom;
      ld_issue_valid = ($urandom_range(0, 1) == 1);
      ld_rd          = 5'($urandom);
      ld_funct3      = 3'($urandom);
      ld_offset      = 2'($urandom);
      mem_rvalid     = ($urandom_range(0, 9) < 4);
      mem_rdata      = $urandom;
      step();
    end
    idle();
    for (int c = 0; c < 10; c++) step();
    check("resp_err_sticky", 32'(resp_err), 32'd1);

    // Reset with loads pending discards them
    do_reset();
    issue(5'd7, 3'b010, 2'd0);
    step();
    issue(5'd9, 3'b000, 2'd1);
    step();
`ifdef WB_SCOREBOARD_EN
    check("rd_pending7", 32'(rd_pending[7]), 32'd1);
`endif
    do_reset();
    check("reset_outst", 32'(ld_outstanding), 32'd0);
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'hABCD;
    step();
    check("late_resp_err", 32'(resp_err), 32'd1);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Producer side of the register file's write port. Merges ALU results and load-return data into the single write port (write_enable / write_address / write_data). Tracks outstanding loads in order and formats returned memory words (LB/LH/LW/LBU/LHU). Buffers load results so ALU writebacks never stall.

Parameters:
DEPTH, 4, max loads in flight, counting both awaiting-response and awaiting-writeback (power of 2, ≥2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_i  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result present this cycle; always accepted
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
ld_issue_valid  in  1  load issued to memory this cycle
ld_issue_ready  out  1  high when outstanding < DEPTH
ld_rd  in  5  load destination register
ld_funct3  in  3  RV32I load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
ld_offset  in  2  address[1:0] of the load
mem_rvalid  in  1  memory response valid; in order; no backpressure
mem_rdata  in  32  aligned memory word
write_enable  out  1  register-file write strobe (registered)
write_address  out  5  register-file write address (registered)
write_data  out  32  register-file write data (registered)
ld_outstanding  out  3  loads in flight: awaiting response + awaiting writeback
resp_err  out  1  sticky: mem_rvalid seen with no load awaiting a response

Behaviour:
- Reset (reset_i low, async): write_enable=0, write_address=0, write_data=0, both FIFOs empty, ld_outstanding=0, resp_err=0, ld_issue_ready=1.
- Meta FIFO (DEPTH entries {rd, funct3, offset}): push on ld_issue_valid && ld_issue_ready. ld_issue_valid while not ready is ignored.
- Result FIFO (DEPTH entries {rd, data}): on mem_rvalid with meta non-empty, pop meta head, format mem_rdata, push result in the same cycle. Capacity is guaranteed because outstanding ≤ DEPTH.
- Formatting (byte lane = offset; halfword lane = offset[1]):
  - LB/LBU: byte sign-/zero-extended.
  - LH/LHU: halfword sign-/zero-extended.
  - LW: word unchanged; offset ignored.
  - Undefined funct3: treated as LW.
- mem_rvalid with meta empty: response dropped, resp_err set to 1 until reset.
- Arbitration, evaluated each cycle:
  - If alu_valid: write ALU result.
  - Else if result FIFO non-empty: pop head and write it.
  - Else: no write.
- Write port latency: exactly 1 cycle.
  - Registers load next edge; write_enable=1 for exactly one cycle per write.
  - A selected entry with rd=0 still pops/consumes but drives write_enable=0 (write_address/write_data still update).
- Same-edge load completion: a load response arriving when the result FIFO is empty is pushed first. It can be written no earlier than the next cycle (1 cycle response→FIFO, +1 to write port).
- Same-edge push and pop on either FIFO: both occur, count unchanged.
- ld_outstanding = meta count + result count.
  - Increments on an accepted issue; decrements when a load result is popped to the write port.
  - Simultaneous issue and pop: unchanged.
  - ld_issue_ready = (ld_outstanding < DEPTH), combinational from state.
- Ordering: loads write back in issue order. Upstream hazard logic is responsible for ALU/load ordering on the same rd.
- Pointers wrap modulo DEPTH; full/empty are distinguished by count, not pointer equality.
- Reset asserted mid-operation: all in-flight loads discarded, outputs return to reset values. Responses arriving after reset release set resp_err.

Optional Feature:
WB_SCOREBOARD_EN:
- Defined: adds output rd_pending [31:0].
  - Bit n=1 while any outstanding load (either FIFO) targets register n, n≠0; bit 0 is always 0.
  - Per-register 3-bit counters: +1 on accepted issue, −1 on result pop.
  - Reset value all 0.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset → write_enable=0, ld_outstanding=0, ld_issue_ready=1, resp_err=0; alu_valid rd=5 data=0x1234 → next cycle write_enable=1, write_address=5, write_data=0x1234.
- Issue LB rd=3 offset=2; respond mem_rdata=0x0080FF00 → write_data=0xFFFFFF80 (0x80 sign-extended), write_address=3. Repeat as LBU → 0x00000080; LHU offset=2 → 0x00000080; LH offset=0 → 0xFFFFFF00.
- Issue 4 loads (rd=1..4) → ld_issue_ready=0, a fifth ld_issue_valid is ignored; respond 4 times while alu_valid is held high → no load writes. Drop alu_valid → writes rd=1,2,3,4 on 4 consecutive cycles, ld_outstanding reaches 0.
- ALU write rd=0 and load to rd=0 → write_enable stays 0, load still retires (ld_outstanding decrements).
- mem_rvalid with nothing outstanding → resp_err=1 and stays 1 through later traffic until reset.
- Reset asserted with 2 loads pending → ld_outstanding=0 immediately; with WB_SCOREBOARD_EN, rd_pending=0; a pending load to rd=7 previously showed rd_pending[7]=1 until its writeback.
